// File: rtl/mem_responder.sv
// mem_responder: single-port 32-bit word memory that answers req/ready handshakes LATENCY cycles after acceptance.
// Optional build macro MEM_MISALIGN_CHECK_EN: misaligned requests are dropped at commit and flagged on err.
module mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);
  localparam bit         DIRECT   = (LATENCY == 1);

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic                  we_q;
  logic [31:0]           wdata_q;
  logic                  accept, commit, c_we, c_mis;
  logic [ADDR_WIDTH-1:0] c_idx;
  logic [31:0]           c_wdata;
  logic [31:0]           mem [DEPTH];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (req) begin
          accept = 1'b1;
          if (DIRECT) begin
            state_nxt = DONE;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_LOAD;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // With LATENCY=1 the commit edge is the accepting edge, so the live inputs are used instead of the latches.
  assign commit  = rst_n && (state_nxt == DONE);
  assign c_idx   = DIRECT ? addr[ADDR_WIDTH+1:2] : idx_q;
  assign c_we    = DIRECT ? we : we_q;
  assign c_wdata = DIRECT ? wdata : wdata_q;

  assign ready = (state == DONE);
  assign busy  = (state == WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        idx_q   <= addr[ADDR_WIDTH+1:2];
        we_q    <= we;
        wdata_q <= wdata;
      end
      if (commit && !c_we && !c_mis) rdata <= mem[c_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (commit && c_we && !c_mis) mem[c_idx] <= c_wdata;
  end

`ifdef MEM_MISALIGN_CHECK_EN
  logic mis_q, err_q;
  logic unused_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (accept) mis_q <= (addr[1:0] != 2'b00);
      err_q <= commit && c_mis;
    end
  end

  assign c_mis       = DIRECT ? (addr[1:0] != 2'b00) : mis_q;
  assign err         = err_q;
  assign unused_addr = ^addr[31:ADDR_WIDTH+2];
`else
  logic unused_addr;

  assign c_mis       = 1'b0;
  assign err         = 1'b0;
  assign unused_addr = ^{addr[31:ADDR_WIDTH+2], addr[1:0]};
`endif

endmodule
